soc_miner_work_fetch: RTL and testbench

AXI4 read-burst engine that fetches a contiguous work buffer (block header plus midstate words) from system memory and streams it, beat by beat, into the hashing datapath. It sits directly upstream of the miner's memory master port: its AR/R signals drive the M_MEMORY_AR*/R* channel of soc_miner. It is started by the register block with a base address and beat count. It splits the transfer into INCR bursts of at most 16 beats that never cross a 4 KB boundary.

---
 rtl/soc_miner_work_fetch_if.sv | 44 ++++
 rtl/soc_miner_work_fetch.sv | 208 ++++++++++++++++++++
 tb/tb_soc_miner_work_fetch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_miner_work_fetch_if.sv
// AXI4 read-address / read-data channel bundle between the work-fetch engine
// (master) and system memory (slave).
interface soc_miner_work_fetch_if #(
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6
);
    logic                            m_memory_arvalid;
    logic                            m_memory_arready;
    logic [MEMORY_ADDR_WIDTH-1:0]    m_memory_araddr;
    logic [MEMORY_BUS_LEN_WIDTH-1:0] m_memory_arlen;
    logic [MEMORY_ID_WIDTH-1:0]      m_memory_arid;
    logic [2:0]                      m_memory_arsize;
    logic [1:0]                      m_memory_arburst;
    logic [1:0]                      m_memory_arlock;
    logic [3:0]                      m_memory_arcache;
    logic [2:0]                      m_memory_arprot;
    logic [3:0]                      m_memory_arqos;
    logic                            m_memory_rvalid;
    logic                            m_memory_rready;
    logic [MEMORY_DATA_WIDTH-1:0]    m_memory_rdata;
    logic                            m_memory_rlast;
    logic [1:0]                      m_memory_rresp;
    logic [MEMORY_ID_WIDTH-1:0]      m_memory_rid;

    // Every transfer completes on a cycle where valid && ready; valid never
    // waits on ready, and payload is held stable while valid && !ready.
    modport master (
        output m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
               m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
               m_memory_arprot, m_memory_arqos, m_memory_rready,
        input  m_memory_arready, m_memory_rvalid, m_memory_rdata, m_memory_rlast,
               m_memory_rresp, m_memory_rid
    );

    modport slave (
        input  m_memory_arvalid, m_memory_araddr, m_memory_arlen, m_memory_arid,
               m_memory_arsize, m_memory_arburst, m_memory_arlock, m_memory_arcache,
               m_memory_arprot, m_memory_arqos, m_memory_rready,
        output m_memory_arready, m_memory_rvalid, m_memory_rdata, m_memory_rlast,
               m_memory_rresp, m_memory_rid
    );
endinterface

// File: rtl/soc_miner_work_fetch.sv
// AXI4 read-burst engine streaming a contiguous work buffer into the hash datapath.
// Optional: define SOC_MINER_FETCH_BYTESWAP_EN to byte-reverse each 32-bit lane of word_data_o.
module soc_miner_work_fetch #(
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6,
    parameter int FETCH_ID             = 0,
    parameter int BEATS_WIDTH          = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         start_i,
    input  logic [MEMORY_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [BEATS_WIDTH-1:0]       num_beats_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    soc_miner_work_fetch_if.master       mem,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [MEMORY_DATA_WIDTH-1:0] word_data_o,
    output logic                         word_last_o,
    output logic [1:0]                   dbg_state_o
);
    localparam int DW    = MEMORY_DATA_WIDTH;
    localparam int AW    = MEMORY_ADDR_WIDTH;
    localparam int LW    = MEMORY_BUS_LEN_WIDTH;
    localparam int BW    = BEATS_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int MAXB  = 2 ** LW;
    localparam logic [LW:0]   ONE_B = 1;
    localparam logic [BW-1:0] ONE_R = 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BW-1:0]   rem_q, rem_d;
    logic [LW:0]     blen_q, blen_d;
    logic [LW:0]     bcnt_q, bcnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW:0]     fifo_q [2];
    logic [DW:0]     fifo_d [2];
    logic            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]      cnt_q, cnt_d;

    logic            ar_valid, r_ready, r_fire, push, push_last, pop, burst_end;
    logic [31:0]     want_len, bnd_len;
    logic [LW:0]     burst_len;
    logic [DW-1:0]   word_raw;

    // Burst is capped by remaining work, the bus maximum, and the 4 KB page edge.
    always_comb begin
        want_len = 32'(rem_q);
        bnd_len  = (32'd4096 - 32'(addr_q[11:0])) >> ALIGN;
        if (want_len > 32'(MAXB)) want_len = 32'(MAXB);
        if (bnd_len < want_len)   want_len = bnd_len;
        burst_len = want_len[LW:0];
    end

    assign r_fire    = mem.m_memory_rvalid && r_ready;
    assign burst_end = (bcnt_q + ONE_B) == blen_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        blen_d    = blen_q;
        bcnt_d    = bcnt_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (num_beats_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = base_addr_i & ~AW'(BYTES - 1);
                        rem_d   = num_beats_i;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                ar_valid = 1'b1;
                if (mem.m_memory_arready) begin
                    blen_d  = burst_len;
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                r_ready = (cnt_q != 2'd2);
                if (r_fire) begin
                    push      = 1'b1;
                    push_last = (rem_q == ONE_R);
                    rem_d     = rem_q - ONE_R;
                    bcnt_d    = bcnt_q + ONE_B;
                    // rlast is only cross-checked; the beat counters decide burst and job ends.
                    if (mem.m_memory_rresp != 2'b00 ||
                        mem.m_memory_rid != MEMORY_ID_WIDTH'(FETCH_ID) ||
                        mem.m_memory_rlast != burst_end)
                        err_d = 1'b1;
                    if (rem_q == ONE_R) begin
                        state_d = S_DONE;
                    end else if (burst_end) begin
                        addr_d  = addr_q + (AW'(blen_q) << ALIGN);
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                if (cnt_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry output buffer; rready already blocks pushes while full.
    always_comb begin
        pop    = (cnt_q != 2'd0) && word_ready_i;
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            fifo_d[wptr_q] = {push_last, mem.m_memory_rdata};
            wptr_d         = ~wptr_q;
        end
        if (pop) rptr_d = ~rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            blen_q    <= '0;
            bcnt_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            blen_q    <= blen_d;
            bcnt_q    <= bcnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign dbg_state_o  = state_q;
    assign word_valid_o = (cnt_q != 2'd0);
    assign {word_last_o, word_raw} = fifo_q[rptr_q];

`ifdef SOC_MINER_FETCH_BYTESWAP_EN
    always_comb begin
        word_data_o = '0;
        for (int l = 0; l < DW / 32; l++)
            for (int b = 0; b < 4; b++)
                word_data_o[l*32 + b*8 +: 8] = word_raw[l*32 + (3-b)*8 +: 8];
    end
`else
    assign word_data_o = word_raw;
`endif

    assign mem.m_memory_arvalid = ar_valid;
    assign mem.m_memory_araddr  = addr_q;
    assign mem.m_memory_arlen   = LW'(burst_len - ONE_B);
    assign mem.m_memory_arid    = MEMORY_ID_WIDTH'(FETCH_ID);
    assign mem.m_memory_arsize  = 3'(ALIGN);
    assign mem.m_memory_arburst = 2'b01;
    assign mem.m_memory_arlock  = 2'b00;
    assign mem.m_memory_arcache = 4'b0011;
    assign mem.m_memory_arprot  = 3'b000;
    assign mem.m_memory_arqos   = 4'b0000;
    assign mem.m_memory_rready  = r_ready;
endmodule

// File: tb/tb_soc_miner_work_fetch.sv
// Bench for soc_miner_work_fetch: memory slave model, job-level reference plan
// (bursts and word stream derived from base/count), scoreboard and summary.
module tb_soc_miner_work_fetch;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int IW = 6;
    localparam int BW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } ar_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    resp;
        logic [IW-1:0] id;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [BW-1:0] num_beats_i;
    logic          busy_o, done_o, error_o;
    logic          word_valid_o, word_ready_i, word_last_o;
    logic [DW-1:0] word_data_o;
    logic [1:0]    dbg_state_o;

    soc_miner_work_fetch_if #(
        .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW),
        .MEMORY_BUS_LEN_WIDTH(LW), .MEMORY_ID_WIDTH(IW)
    ) mem_if ();

    soc_miner_work_fetch dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_beats_i (num_beats_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .mem         (mem_if),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .word_data_o (word_data_o),
        .word_last_o (word_last_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    ar_t          exp_ar_q[$];
    logic [DW:0]  exp_q[$];
    beat_t        beat_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           rdy_mode = 0;
    bit           stall    = 1'b0;
    int           inj_idx  = -1;
    int           inj_kind = 0;
    int           job_beat = 0;
    bit           hold_valid = 1'b0;
    logic [DW-1:0] hold_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 32'h5a5a_1234, a * 32'h9e37_79b9};
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
        logic [DW-1:0] s;
        s = w;
`ifdef SOC_MINER_FETCH_BYTESWAP_EN
        for (int l = 0; l < DW / 32; l++)
            for (int b = 0; b < 4; b++)
                s[l*32 + b*8 +: 8] = w[l*32 + (3-b)*8 +: 8];
`endif
        return s;
    endfunction

    // Expected words follow the contiguous address range; bursts follow the page/length rules.
    task automatic plan_job(input logic [AW-1:0] base, input int num);
        logic [AW-1:0] a;
        int rem, len, bnd;
        a = base & ~AW'(DW / 8 - 1);
        for (int i = 0; i < num; i++)
            exp_q.push_back({(i == num - 1), exp_word(mem_word(a + AW'(i * 8)))});
        rem = num;
        while (rem > 0) begin
            bnd = (4096 - int'(a % 4096)) / 8;
            len = rem;
            if (len > 16)  len = 16;
            if (len > bnd) len = bnd;
            exp_ar_q.push_back('{addr: a, len: LW'(len - 1)});
            a   = a + AW'(len * 8);
            rem = rem - len;
        end
    endtask

    // Memory slave and output sink: drive at negedge, resolve handshakes just after.
    initial begin
        ar_t   e;
        beat_t b;
        logic [DW:0] w;
        mem_if.m_memory_arready = 1'b0;
        mem_if.m_memory_rvalid  = 1'b0;
        mem_if.m_memory_rdata   = '0;
        mem_if.m_memory_rlast   = 1'b0;
        mem_if.m_memory_rresp   = 2'b00;
        mem_if.m_memory_rid     = '0;
        word_ready_i            = 1'b0;
        forever begin
            @(negedge clk);
            mem_if.m_memory_arready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (beat_q.size() > 0 && (rdy_mode == 0 || $urandom_range(0, 3) != 0)) begin
                mem_if.m_memory_rvalid = 1'b1;
                mem_if.m_memory_rdata  = beat_q[0].data;
                mem_if.m_memory_rlast  = beat_q[0].last;
                mem_if.m_memory_rresp  = beat_q[0].resp;
                mem_if.m_memory_rid    = beat_q[0].id;
            end else begin
                mem_if.m_memory_rvalid = 1'b0;
                mem_if.m_memory_rdata  = {$urandom, $urandom};
                mem_if.m_memory_rlast  = 1'b0;
                mem_if.m_memory_rresp  = 2'b00;
                mem_if.m_memory_rid    = '0;
            end
            word_ready_i = stall ? 1'b0 : ((rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
            #1;
            if (hold_valid) check("hold", word_data_o, hold_word);
            hold_valid = word_valid_o && !word_ready_i;
            hold_word  = word_data_o;
            if (mem_if.m_memory_arvalid && mem_if.m_memory_arready) begin
                if (exp_ar_q.size() == 0) begin
                    check("ar_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_ar_q.pop_front();
                    check("ar_addr", 64'(mem_if.m_memory_araddr), 64'(e.addr));
                    check("ar_len", 64'(mem_if.m_memory_arlen), 64'(e.len));
                    for (int i = 0; i <= int'(e.len); i++) begin
                        b.data = mem_word(e.addr + AW'(i * 8));
                        b.last = (i == int'(e.len));
                        b.resp = 2'b00;
                        b.id   = '0;
                        if (job_beat == inj_idx) begin
                            case (inj_kind)
                                0:       b.resp = 2'b10;
                                1:       b.id   = IW'(5);
                                default: b.last = ~b.last;
                            endcase
                        end
                        job_beat++;
                        beat_q.push_back(b);
                    end
                end
            end
            if (mem_if.m_memory_rvalid && mem_if.m_memory_rready) void'(beat_q.pop_front());
            if (word_valid_o && word_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("word_extra", 64'd1, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", word_data_o, w[DW-1:0]);
                    check("word_last", 64'(word_last_o), 64'(w[DW]));
                end
            end
        end
    end

    task automatic run_job(input logic [AW-1:0] base, input int num, input int idx, input int kind);
        int cyc;
        bit err_exp;
        plan_job(base, num);
        inj_idx  = idx;
        inj_kind = kind;
        job_beat = 0;
        err_exp  = (idx >= 0 && idx < num);
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        num_beats_i = BW'(num);
        @(posedge clk);
        #1;
        check("busy_start", 64'(busy_o), 64'd1);
        check("err_clear", 64'(error_o), 64'd0);
        @(negedge clk);
        start_i     = 1'b0;
        base_addr_i = $urandom;
        num_beats_i = BW'($urandom);
        cyc = 0;
        while (!done_o && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", 64'(done_o), 64'd1);
        if (num == 0) check("zero_latency", 64'(cyc), 64'd1);
        check("busy_at_done", 64'(busy_o), 64'd0);
        check("error", 64'(error_o), 64'(err_exp));
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("ars_left", 64'(exp_ar_q.size()), 64'd0);
        check("beats_left", 64'(beat_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done_o), 64'd0);
        check("error_hold", 64'(error_o), 64'(err_exp));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_error"}, 64'(error_o), 64'd0);
        check({tag, "_arvalid"}, 64'(mem_if.m_memory_arvalid), 64'd0);
        check({tag, "_rready"}, 64'(mem_if.m_memory_rready), 64'd0);
        check({tag, "_wvalid"}, 64'(word_valid_o), 64'd0);
        check({tag, "_wdata"}, word_data_o, 64'd0);
        check({tag, "_wlast"}, 64'(word_last_o), 64'd0);
    endtask

    initial begin
        int cyc, num, idx;
        logic [AW-1:0] base;
        rst         = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        num_beats_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("arsize", 64'(mem_if.m_memory_arsize), 64'd3);
        check("arburst", 64'(mem_if.m_memory_arburst), 64'd1);
        check("arcache", 64'(mem_if.m_memory_arcache), 64'd3);
        check("arid", 64'(mem_if.m_memory_arid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        rdy_mode = 0;
        run_job(32'h0000_1000, 10, -1, 0);
        run_job(32'h0000_0FF0, 20, -1, 0);
        run_job(32'h0000_5000, 0, -1, 0);

        // Output stalled for five cycles in the middle of a burst.
        fork
            run_job(32'h0000_2000, 16, -1, 0);
            begin
                repeat (4) @(posedge clk);
                #2 stall = 1'b1;
                repeat (4) @(posedge clk);
                #2;
                check("stall_rready", 64'(mem_if.m_memory_rready), 64'd0);
                check("stall_valid", 64'(word_valid_o), 64'd1);
                @(posedge clk);
                #2 stall = 1'b0;
            end
        join

        run_job(32'h0000_4000, 4, 2, 0);
        run_job(32'h0000_4100, 3, -1, 0);

        // Reset while the output buffer is full and beats are still pending.
        plan_job(32'h0000_3000, 8);
        inj_idx  = -1;
        job_beat = 0;
        stall    = 1'b1;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 32'h0000_3000;
        num_beats_i = 8'd8;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!(word_valid_o && !mem_if.m_memory_rready && busy_o) && cyc < 50) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("full_before_reset", 64'(word_valid_o && !mem_if.m_memory_rready), 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        exp_ar_q.delete();
        beat_q.delete();
        hold_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        run_job(32'h0000_3000, 8, -1, 0);

        // Randomized jobs: random readiness, page edges, address wrap, injected faults.
        rdy_mode = 1;
        for (int j = 0; j < 14; j++) begin
            case ($urandom_range(0, 2))
                0:       base = {$urandom} & ~32'h7;
                1:       base = {$urandom_range(0, 32'hFFFFF), 12'hF00} + 32'({$urandom_range(0, 31), 3'b000});
                default: base = 32'hFFFF_FF00 + 32'({$urandom_range(0, 31), 3'b000});
            endcase
            num = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
            idx = (num > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, num - 1) : -1;
            run_job(base, num, idx, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
